// File: rtl/median_seq.sv
// Sequential 9-sample median filter: a 9-entry ring is swept five times through one
// compare/exchange element; each sweep removes the current maximum, so sweep 4 yields the median.

module MCE #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  output logic [DATA_W-1:0] MAX,
  output logic [DATA_W-1:0] MIN
);
  always_comb begin
    if (A >= B) begin
      MAX = A;
      MIN = B;
    end else begin
      MAX = B;
      MIN = A;
    end
  end
endmodule

module median_seq #(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [DATA_W-1:0] DI,
  input  logic              DSI,
  output logic [DATA_W-1:0] DO,
  output logic              DSO,
  output logic              BUSY
);
  localparam logic [0:0] LOAD    = 1'b0;
  localparam logic [0:0] COMPUTE = 1'b1;

  logic [0:0]        state;
  logic [DATA_W-1:0] ring [0:8];
  logic [DATA_W-1:0] t_acc;
  logic [3:0]        load_cnt;
  logic [2:0]        pass_cnt;
  logic [3:0]        step_cnt;
  logic [DATA_W-1:0] mce_max;
  logic [DATA_W-1:0] mce_min;

  MCE #(.DATA_W(DATA_W)) u_mce (
    .A   (t_acc),
    .B   (ring[8]),
    .MAX (mce_max),
    .MIN (mce_min)
  );

  assign BUSY = (state == COMPUTE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= LOAD;
      load_cnt <= '0;
      pass_cnt <= '0;
      step_cnt <= '0;
      t_acc    <= '0;
      DO       <= '0;
      DSO      <= 1'b0;
      for (int k = 0; k < 9; k++) ring[k] <= '0;
    end else begin
      DSO <= 1'b0;
      if (state == LOAD) begin
        if (DSI) begin
          for (int k = 8; k > 0; k--) ring[k] <= ring[k-1];
          ring[0] <= DI;
          if (load_cnt == 4'd8) begin
            state    <= COMPUTE;
            load_cnt <= '0;
            pass_cnt <= '0;
            step_cnt <= '0;
          end else begin
            load_cnt <= load_cnt + 4'd1;
          end
        end
      end else begin
        // Step 0 seeds the running max and plants a zero that stands in for the removed maximum.
        for (int k = 8; k > 0; k--) ring[k] <= ring[k-1];
        if (step_cnt == 4'd0) begin
          t_acc   <= ring[8];
          ring[0] <= '0;
        end else begin
          t_acc   <= mce_max;
          ring[0] <= mce_min;
        end
        if (step_cnt == 4'd8) begin
          step_cnt <= '0;
          if (pass_cnt == 3'd4) begin
            DO       <= mce_max;
            DSO      <= 1'b1;
            state    <= LOAD;
            pass_cnt <= '0;
          end else begin
            pass_cnt <= pass_cnt + 3'd1;
          end
        end else begin
          step_cnt <= step_cnt + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_median_seq.sv
// Directed and random checks for median_seq: latency, busy window, ties, extremes,
// DSI during compute, mid-compute reset and a software median reference.

module tb_median_seq;
  logic       CLK;
  logic       nRST;
  logic [7:0] DI;
  logic       DSI;
  logic [7:0] DO;
  logic       DSO;
  logic       BUSY;

  int n_checks = 0;
  int n_fail   = 0;

  median_seq dut (
    .CLK  (CLK),
    .nRST (nRST),
    .DI   (DI),
    .DSI  (DSI),
    .DO   (DO),
    .DSO  (DSO),
    .BUSY (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic push(input logic [7:0] v, input int gap);
    @(negedge CLK);
    DSI = 1'b1;
    DI  = v;
    for (int g = 0; g < gap; g++) begin
      @(negedge CLK);
      DSI = 1'b0;
    end
  endtask

  // Called right after the 9th push; lat counts compute edges until DSO is seen (-1 on timeout).
  task automatic wait_dso(input bit hold, output int lat, output logic [7:0] val, output int busy_cnt);
    lat = -1;
    val = 8'h00;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (hold) begin
        DSI = 1'b1;
        DI  = 8'hAA;
      end else begin
        DSI = 1'b0;
      end
      if (DSO) begin
        lat = i;
        val = DO;
        break;
      end
      if (BUSY) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    DSI  = 1'b0;
    DI   = 8'h00;
    #1;
    n_checks++;
    if ({DO, DSO, BUSY} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got DO=%0d DSO=%0d BUSY=%0d expected all 0", DO, DSO, BUSY);
    end
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_incrementing();
    int lat, busy_cnt;
    logic [7:0] val;
    for (int i = 1; i <= 9; i++) push(8'(i), 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (lat !== 45) begin
      n_fail++;
      $display("FAIL inc_latency: got %0d expected 45", lat);
    end
    n_checks++;
    if (val !== 8'd5) begin
      n_fail++;
      $display("FAIL inc_median: got %0d expected 5", val);
    end
    n_checks++;
    if (busy_cnt !== 45) begin
      n_fail++;
      $display("FAIL inc_busy_cycles: got %0d expected 45", busy_cnt);
    end
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL inc_busy_in_dso_cycle: got %0d expected 0", BUSY);
    end
    @(negedge CLK);
    n_checks++;
    if (DSO !== 1'b0 || DO !== 8'd5) begin
      n_fail++;
      $display("FAIL inc_dso_pulse_hold: got DSO=%0d DO=%0d expected DSO=0 DO=5", DSO, DO);
    end
  endtask

  task automatic test_gaps_ties();
    int lat, busy_cnt;
    logic [7:0] val;
    logic [7:0] w1 [9] = '{8'd255, 8'd0, 8'd200, 8'd3, 8'd128, 8'd128, 8'd7, 8'd255, 8'd1};
    logic [7:0] w2 [9] = '{8'd7, 8'd7, 8'd7, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9};
    for (int i = 0; i < 9; i++) push(w1[i], (i < 8) ? (i % 3) + 1 : 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'd128 || lat !== 45) begin
      n_fail++;
      $display("FAIL gaps_median: got %0d lat %0d expected 128 lat 45", val, lat);
    end
    for (int i = 0; i < 9; i++) push(w2[i], 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'd7) begin
      n_fail++;
      $display("FAIL ties_median: got %0d expected 7", val);
    end
  endtask

  task automatic test_extremes();
    int lat, busy_cnt;
    logic [7:0] val;
    for (int i = 0; i < 9; i++) push(8'h00, 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'h00 || lat !== 45) begin
      n_fail++;
      $display("FAIL all_zero_median: got %0d lat %0d expected 0 lat 45", val, lat);
    end
    for (int i = 0; i < 9; i++) push(8'hFF, 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'hFF) begin
      n_fail++;
      $display("FAIL all_ff_median: got %0d expected 255", val);
    end
  endtask

  task automatic test_busy_ignore();
    int lat, busy_cnt;
    logic [7:0] val;
    for (int i = 9; i >= 1; i--) push(8'(i), 0);
    wait_dso(1'b1, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'd5 || lat !== 45) begin
      n_fail++;
      $display("FAIL busy_ignore_median: got %0d lat %0d expected 5 lat 45", val, lat);
    end
    // 0xAA presented in the DSO cycle is sample 1; eight more complete the window {170,10..80}.
    for (int i = 1; i <= 8; i++) push(8'(i * 10), 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'd50 || lat !== 45) begin
      n_fail++;
      $display("FAIL dso_cycle_sample: got %0d lat %0d expected 50 lat 45", val, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy_cnt, dso_seen;
    logic [7:0] val;
    for (int i = 0; i < 9; i++) push(8'(100 + i), 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      DSI = 1'b0;
    end
    nRST = 1'b0;
    #1;
    n_checks++;
    if ({DO, DSO, BUSY} !== 10'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got DO=%0d DSO=%0d BUSY=%0d expected all 0", DO, DSO, BUSY);
    end
    @(negedge CLK);
    nRST = 1'b1;
    dso_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (DSO) dso_seen++;
    end
    n_checks++;
    if (dso_seen !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_no_dso: got %0d pulses expected 0", dso_seen);
    end
    for (int i = 0; i < 9; i++) push(8'(60 - i * 5), 0);
    wait_dso(1'b0, lat, val, busy_cnt);
    n_checks++;
    if (val !== 8'd40 || lat !== 45) begin
      n_fail++;
      $display("FAIL mid_reset_fresh_median: got %0d lat %0d expected 40 lat 45", val, lat);
    end
  endtask

  task automatic test_random();
    int lat, busy_cnt;
    logic [7:0] val, tmp, expv;
    logic [7:0] w [9];
    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < 9; i++) w[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 9; i++) push(w[i], 0);
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8 - i; j++)
          if (w[j] > w[j+1]) begin
            tmp = w[j];
            w[j] = w[j+1];
            w[j+1] = tmp;
          end
      expv = w[4];
      wait_dso(1'b0, lat, val, busy_cnt);
      n_checks++;
      if (val !== expv || lat !== 45) begin
        n_fail++;
        $display("FAIL random_median[%0d]: got %0d lat %0d expected %0d lat 45", n, val, lat, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_gaps_ties();
    test_extremes();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/median_seq.md
MEDIAN_SEQ -- requirements
Module: median_seq

Interface
REQ-001 SHALL have port CLK, input, 1 bit: single system clock, all state updates on rising edge.
REQ-002 SHALL have port nRST, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port DI, input, 8 bits: unsigned pixel value to load.
REQ-004 SHALL have port DSI, input, 1 bit: DI valid strobe, sampled on each CLK rising edge.
REQ-005 SHALL have port DO, output, 8 bits: median result, registered.
REQ-006 SHALL have port DSO, output, 1 bit: one-cycle pulse marking a new DO.
REQ-007 SHALL have port BUSY, output, 1 bit: high while computing; DSI ignored.
REQ-008 SHALL instantiate exactly one MCE (A, B -> MAX, MIN, 8-bit unsigned) as its only comparator.

Function
REQ-009 SHALL hold a 9-entry 8-bit ring R[0..8], an 8-bit accumulator T, a load counter (0..8), a pass counter (0..4) and a step counter (0..8).
REQ-010 SHALL implement two states: LOAD (BUSY=0) and COMPUTE (BUSY=1).
REQ-011 In LOAD, each edge with DSI=1 SHALL shift R[k]<=R[k-1] for k=1..8, set R[0]<=DI and increment the load counter; DSI=0 SHALL leave all state unchanged.
REQ-012 The edge sampling the 9th DSI SHALL move LOAD->COMPUTE, clear the load counter and clear the pass and step counters.
REQ-013 COMPUTE step 0 of each pass SHALL set T<=R[8], shift R[k]<=R[k-1] for k=1..8 and set R[0]<=8'h00.
REQ-014 COMPUTE steps 1..8 SHALL drive MCE A=T, B=R[8], then set T<=MAX, shift R[k]<=R[k-1] for k=1..8 and set R[0]<=MIN.
REQ-015 After step 8 the pass counter SHALL increment and the step counter SHALL return to 0; T of passes 0..3 is discarded.
REQ-016 On step 8 of pass 4 (the 45th COMPUTE edge), the block SHALL set DO<=MAX and DSO<=1, and SHALL return to LOAD.
REQ-017 DSO SHALL be high for exactly one cycle; DO SHALL hold its value until the next result.
REQ-018 Latency from the edge sampling the 9th DSI to the edge registering DO/DSO SHALL be exactly 45 cycles.
REQ-019 DSI asserted while BUSY=1 SHALL be ignored: no shift, no counter change, and the value is not queued.
REQ-020 DSI asserted during the DSO cycle SHALL be accepted as the 1st sample of the next window.
REQ-021 All comparisons SHALL be unsigned.
REQ-022 Ties and zero-valued pixels SHALL yield the correct median, since inserted 8'h00 entries never exceed any pixel.
REQ-023 Each window SHALL be independent: no pixel carries over between windows.

Reset
REQ-024 nRST=0 SHALL immediately force state=LOAD, all counters=0, R[0..8]=0, T=0, DO=8'h00, DSO=0 and BUSY=0.
REQ-025 Reset asserted mid-LOAD or mid-COMPUTE SHALL discard the partial window and produce no DSO pulse.
REQ-026 After nRST deassertion, the first DSI=1 edge SHALL be taken as sample 1 of a new window.

Verification
REQ-027 Load 1,2,...,9 on 9 consecutive cycles -> DSO high exactly 45 cycles after the 9th DSI edge with DO=5; BUSY high for those 45 cycles.
REQ-028 Load 255,0,200,3,128,128,7,255,1 with idle gaps between DSI pulses -> DO=128; loads 7,7,7,1,1,1,9,9,9 -> DO=7.
REQ-029 Load all 8'h00 -> DO=0; load all 8'hFF -> DO=255.
REQ-030 Hold DSI=1 with DI=8'hAA throughout COMPUTE after loading 9..1 -> DO=5, and the next window starts with the DI presented in the DSO cycle.
REQ-031 Pulse nRST low at COMPUTE cycle 20 -> outputs zero immediately, no DSO; a fresh 9-sample load then gives the correct median.
REQ-032 Run 1000 random 9-sample windows -> DO equals a sorted-array software median on every DSO.
